// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: shared helpers for the dual-clock FIFO pointer logic.
// Provides the depth helper, Gray encoding and the "full" pointer compare.
// Pointers are passed in a wide zero-extended container so that one set of
// functions serves every SIZE; callers cast to and from their own ptr_t.
package fifo_ptr_pkg;

   localparam int unsigned PTR_W_MAX = 32;

   // Wide container for pointers of any width up to PTR_W_MAX bits.
   typedef logic [PTR_W_MAX-1:0] ptr_wide_t;

   // Number of FIFO entries for a given address width.
   function automatic int unsigned depth(input int unsigned size);
      return 32'd1 << size;
   endfunction

   // Binary to reflected Gray code. Zero-extension leaves the result intact.
   function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
      return b ^ (b >> 1);
   endfunction

   // Full when the write pointer is exactly one lap ahead of the read pointer.
   // In Gray code this means the two top bits differ and the rest are equal.
   // size is the address width; the pointers are size+1 bits wide.
   function automatic logic full_match(input ptr_wide_t   wgray,
                                       input ptr_wide_t   rgray,
                                       input int unsigned size);
      ptr_wide_t flip;
      flip = ptr_wide_t'(2'b11) << (size - 1);
      return wgray == (rgray ^ flip);
   endfunction

endpackage

// File: rtl/gray_decode.sv
// gray_decode: combinational Gray to binary converter.
// Each binary bit is the XOR of the Gray bits at and above its position.
module gray_decode #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   // Prefix XOR from the MSB down.
   always_comb begin
      bin_o = '0;
      for (int i = 0; i < W; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule

// File: rtl/gray_wptr_gen.sv
// gray_wptr_gen: write-side pointer generator for the dual-clock FIFO.
// Holds the binary write pointer, drives the RAM write address and a
// registered Gray pointer for the read-domain synchroniser, and produces a
// registered full flag from the synchronised read pointer.
// Optional feature: define ALMOST_FULL_EN to add the registered almost_full_o
// output (read pointer decode plus occupancy subtractor).
module gray_wptr_gen
   import fifo_ptr_pkg::*;
#(
   parameter int unsigned SIZE      = 4,
   parameter int unsigned AF_MARGIN = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            inc_i,
   input  logic [SIZE:0]   rptr_gray_sync_i,
   output logic [SIZE-1:0] waddr_o,
   output logic [SIZE:0]   wptr_gray_o,
   output logic            full_o,
   output logic            wr_en_o
`ifdef ALMOST_FULL_EN
   ,
   output logic            almost_full_o
`endif
);

   typedef logic [SIZE:0] ptr_t;

   ptr_t wbin_q;
   ptr_t wbin_d;
   ptr_t wgray_q;
   ptr_t wgray_d;
   logic full_q;
   logic full_d;
   logic push;

   // A push is taken only outside reset and while there is room; this strobe
   // is also the RAM write enable.
   assign push    = inc_i & ~full_q & ~rst_i;
   assign wr_en_o = push;

   // Next pointer values and full evaluation against the current read sample.
   always_comb begin
      wbin_d  = wbin_q + ptr_t'(push);
      wgray_d = ptr_t'(bin2gray(ptr_wide_t'(wbin_d)));
      full_d  = full_match(ptr_wide_t'(wgray_d), ptr_wide_t'(rptr_gray_sync_i), SIZE);
   end

   // Pointer and full registers; Gray output is taken straight from a flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         full_q  <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         full_q  <= full_d;
      end
   end

   assign waddr_o     = wbin_q[SIZE-1:0];
   assign wptr_gray_o = wgray_q;
   assign full_o      = full_q;

`ifdef ALMOST_FULL_EN
   localparam int unsigned DEPTH = depth(SIZE);

   // One extra bit so the free-slot count can represent the full depth.
   typedef logic [SIZE+1:0] room_t;

   ptr_t  rbin;
   ptr_t  used;
   room_t free_slots;
   logic  af_d;
   logic  af_q;

   gray_decode #(
      .W (SIZE + 1)
   ) u_rptr_decode (
      .gray_i (rptr_gray_sync_i),
      .bin_o  (rbin)
   );

   // Occupancy after this cycle's push, measured against the read sample.
   always_comb begin
      used       = wbin_d - rbin;
      free_slots = room_t'(DEPTH) - room_t'(used);
      af_d       = (free_slots <= room_t'(AF_MARGIN));
   end

   // Registered almost-full flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         af_q <= 1'b0;
      end else begin
         af_q <= af_d;
      end
   end

   assign almost_full_o = af_q;
`endif

endmodule

// File: tb/tb_gray_wptr_gen.sv
// tb_gray_wptr_gen: directed scenarios followed by randomized traffic, all
// compared against an occupancy-counting reference model.
module tb_gray_wptr_gen;

   localparam int SIZE   = 4;
   localparam int DEPTH  = 16;
   localparam int AF     = 2;
   localparam int PMOD   = 32;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            inc_i = 1'b0;
   logic [SIZE:0]   rptr_gray_sync_i = '0;
   logic [SIZE-1:0] waddr_o;
   logic [SIZE:0]   wptr_gray_o;
   logic            full_o;
   logic            wr_en_o;
`ifdef ALMOST_FULL_EN
   logic            almost_full_o;
`endif

   gray_wptr_gen #(
      .SIZE      (SIZE),
      .AF_MARGIN (AF)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .inc_i            (inc_i),
      .rptr_gray_sync_i (rptr_gray_sync_i),
      .waddr_o          (waddr_o),
      .wptr_gray_o      (wptr_gray_o),
      .full_o           (full_o),
      .wr_en_o          (wr_en_o)
`ifdef ALMOST_FULL_EN
      ,
      .almost_full_o    (almost_full_o)
`endif
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   // Reference model: pushes written and entries read, as plain counters.
   int  m_w    = 0;
   int  m_r    = 0;
   logic m_full = 1'b0;
   logic m_af   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [SIZE:0] to_gray(input int b);
      logic [SIZE:0] v;
      v = (SIZE+1)'(b);
      return v ^ (v >> 1);
   endfunction

   // One clock cycle: drive, check the push strobe, clock, update model, check.
   task automatic step(input logic inc, input int rnext, input logic rst);
      logic          exp_wr;
      logic [SIZE:0] prev_gray;
      int            occ;
      @(negedge clk);
      inc_i            = inc;
      rst_i            = rst;
      m_r              = rnext & (PMOD - 1);
      rptr_gray_sync_i = to_gray(m_r);
      #1;
      exp_wr = !rst && inc && !m_full;
      chk("wr_en", 32'(wr_en_o), 32'(exp_wr));
      prev_gray = wptr_gray_o;
      @(posedge clk);
      #1;
      if (rst) begin
         m_w    = 0;
         m_full = 1'b0;
         m_af   = 1'b0;
      end else begin
         if (exp_wr) m_w = (m_w + 1) % PMOD;
         occ    = (m_w - m_r + PMOD) % PMOD;
         m_full = (occ == DEPTH);
         m_af   = ((DEPTH - occ) <= AF);
      end
      chk("gray",  32'(wptr_gray_o), 32'(to_gray(m_w)));
      chk("waddr", 32'(waddr_o),     32'(m_w % DEPTH));
      chk("full",  32'(full_o),      32'(m_full));
`ifdef ALMOST_FULL_EN
      chk("afull", 32'(almost_full_o), 32'(m_af));
`endif
      if (!rst) begin
         chk("gray_onebit", 32'($countones(prev_gray ^ wptr_gray_o)), exp_wr ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      int occ;
      int guard;

      // Reset with push requested: nothing may be accepted.
      for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1);
      chk("rst_gray",  32'(wptr_gray_o), 32'd0);
      chk("rst_waddr", 32'(waddr_o),     32'd0);
      chk("rst_full",  32'(full_o),      32'd0);

      // Fill: 16 consecutive pushes, address running 0..15.
      for (int i = 0; i < DEPTH; i++) begin
         chk("fill_waddr", 32'(waddr_o), 32'(i));
         step(1'b1, 0, 1'b0);
      end
      chk("fill_full", 32'(full_o),      32'd1);
      chk("fill_gray", 32'(wptr_gray_o), 32'b11000);

      // Overflow: pushes while full are dropped.
      for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0);
      chk("ovf_gray", 32'(wptr_gray_o), 32'b11000);
      chk("ovf_full", 32'(full_o),      32'd1);

      // Drain release: one read frees a slot, one push refills it.
      step(1'b0, 1, 1'b0);
      chk("drain_full", 32'(full_o), 32'd0);
      step(1'b1, 1, 1'b0);
      chk("refill_full", 32'(full_o),      32'd1);
      chk("refill_gray", 32'(wptr_gray_o), 32'b11001);

      // Wrap: push with the reader trailing by a few entries until wbin wraps.
      guard = 0;
      while (m_w != 0 && guard < 40) begin
         step(1'b1, m_w - 7, 1'b0);
         guard++;
      end
      chk("wrap_reached", 32'(m_w),         32'd0);
      chk("wrap_gray",    32'(wptr_gray_o), 32'd0);
      chk("wrap_waddr",   32'(waddr_o),     32'd0);
      chk("wrap_full",    32'(full_o),      32'd0);

`ifdef ALMOST_FULL_EN
      // Almost-full threshold from an empty FIFO.
      step(1'b0, 0, 1'b1);
      for (int i = 0; i < 13; i++) step(1'b1, 0, 1'b0);
      chk("af_13", 32'(almost_full_o), 32'd0);
      step(1'b1, 0, 1'b0);
      chk("af_14", 32'(almost_full_o), 32'd1);
      step(1'b0, 2, 1'b0);
      chk("af_release", 32'(almost_full_o), 32'd0);
`endif

      // Randomized traffic with occasional resets; reader never overtakes.
      step(1'b0, 0, 1'b1);
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            step(1'b1, 0, 1'b1);
         end else begin
            occ = (m_w - m_r + PMOD) % PMOD;
            if (occ > 0 && $urandom_range(0, 99) < 40) begin
               step(1'($urandom_range(0, 99) < 70), m_r + 1, 1'b0);
            end else begin
               step(1'($urandom_range(0, 99) < 70), m_r, 1'b0);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
